// File: rtl/seg_display_sched_if.sv
// Bundle of requester inputs and display outputs for the seven-segment scheduler.
interface seg_display_sched_if;
    logic        req0;
    logic [15:0] val0;
    logic        req1;
    logic [15:0] val1;
    logic [1:0]  gnt;
    logic [3:0]  LEDSEL;
    logic [7:0]  LEDOUT;
    logic        frame_done;

    // Requesters (and the bench) drive requests and watch the display.
    modport master (
        output req0, val0, req1, val1,
        input  gnt, LEDSEL, LEDOUT, frame_done
    );

    // The scheduler consumes requests and drives the display.
    modport slave (
        input  req0, val0, req1, val1,
        output gnt, LEDSEL, LEDOUT, frame_done
    );
endinterface

// File: rtl/seg_display_sched.sv
// Four-digit multiplexed seven-segment scheduler: arbitrates between two
// BCD requesters on frame boundaries, scans digits with a blank interval
// before each drive period and suppresses leading zeros.
module seg_display_sched #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int HOLD_FRAMES = 64
) (
    input  logic                clk50MHz,
    input  logic                rst,
    seg_display_sched_if.slave  bus
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_FRAMES);

    typedef enum logic {S_BLANK, S_DRIVE} scan_t;

    scan_t          state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     digit_q, digit_d;
    logic           first_q, first_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [15:0]    val_q, val_d;
    logic [3:0]     ledsel_q, ledsel_d;
    logic [7:0]     ledout_q, ledout_d;
    logic           frame_done_q, frame_done_d;

    logic           boundary;
    logic           own_req, oth_req;

    // Active-low segment pattern for one BCD nibble; non-decimal nibbles go dark.
    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 8'h88;
            4'd1:    return 8'hed;
            4'd2:    return 8'ha2;
            4'd3:    return 8'ha4;
            4'd4:    return 8'hc5;
            4'd5:    return 8'h94;
            4'd6:    return 8'h90;
            4'd7:    return 8'had;
            4'd8:    return 8'h80;
            4'd9:    return 8'h84;
            default: return 8'hff;
        endcase
    endfunction

    // Pattern for digit idx of v, blanking a digit whose nibble and all higher ones are zero.
    function automatic logic [7:0] digit_pattern(input logic [15:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    return seg_decode(v[3:0]);
            2'd1:    return (v[15:4]  == 12'd0) ? 8'hff : seg_decode(v[7:4]);
            2'd2:    return (v[15:8]  == 8'd0)  ? 8'hff : seg_decode(v[11:8]);
            default: return (v[15:12] == 4'd0)  ? 8'hff : seg_decode(v[15:12]);
        endcase
    endfunction

    // Scan FSM: blank interval, then drive, then advance to the next digit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        digit_d = digit_q;
        first_d = 1'b0;
        case (state_q)
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                end
            end
            default: state_d = S_BLANK;
        endcase
        // Registered, so it is computed from where the scan is heading.
        frame_done_d = (state_d == S_DRIVE) && (digit_d == 2'd3) && (cnt_d == SLOT_LAST);
    end

    // Ownership, hold count and value capture only move on frame boundaries.
    always_comb begin
        boundary = first_q | frame_done_q;
        own_req  = gnt_q[0] ? bus.req0 : bus.req1;
        oth_req  = gnt_q[0] ? bus.req1 : bus.req0;
        gnt_d    = gnt_q;
        hold_d   = hold_q;
        val_d    = val_q;
        if (boundary) begin
            if (gnt_q == 2'b00) begin
                if (bus.req0) begin
                    gnt_d  = 2'b01;
                    hold_d = HW'(1);
                    val_d  = bus.val0;
                end else if (bus.req1) begin
                    gnt_d  = 2'b10;
                    hold_d = HW'(1);
                    val_d  = bus.val1;
                end
            end else if (own_req && ((hold_q < HOLD_MAX) || !oth_req)) begin
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
                val_d  = gnt_q[0] ? bus.val0 : bus.val1;
            end else if (oth_req) begin
                gnt_d  = gnt_q[0] ? 2'b10 : 2'b01;
                hold_d = HW'(1);
                val_d  = gnt_q[0] ? bus.val1 : bus.val0;
            end else begin
                gnt_d  = 2'b00;
                hold_d = '0;
            end
        end
    end

    // Display outputs follow the next scan state so they change on entry to it.
    always_comb begin
        ledsel_d = 4'b1111;
        ledout_d = 8'hff;
        if ((state_d == S_DRIVE) && (gnt_d != 2'b00)) begin
            ledsel_d = ~(4'b0001 << digit_d);
            ledout_d = digit_pattern(val_d, digit_d);
        end
    end

    // State registers; first_q marks the boundary right after reset release.
    always_ff @(posedge clk50MHz) begin
        if (rst) begin
            state_q      <= S_BLANK;
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            first_q      <= 1'b1;
            gnt_q        <= 2'b00;
            hold_q       <= '0;
            val_q        <= 16'h0000;
            ledsel_q     <= 4'b1111;
            ledout_q     <= 8'hff;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            first_q      <= first_d;
            gnt_q        <= gnt_d;
            hold_q       <= hold_d;
            val_q        <= val_d;
            ledsel_q     <= ledsel_d;
            ledout_q     <= ledout_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.LEDSEL     = ledsel_q;
    assign bus.LEDOUT     = ledout_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed bench for seg_display_sched with a 32-cycle frame
// (REFRESH_DIV=8, BLANK_CYC=2, HOLD_FRAMES=2).
module tb_seg_display_sched;

    logic clk;
    logic rst;
    int   tests;
    int   failed;
    int   cyc;

    seg_display_sched_if bus();

    seg_display_sched #(
        .REFRESH_DIV (8),
        .BLANK_CYC   (2),
        .HOLD_FRAMES (2)
    ) dut (
        .clk50MHz (clk),
        .rst      (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    // After this, cyc 0 is the first cycle with rst low (the first boundary).
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic [7:0] pat [4];
        logic [3:0] es;
        logic [7:0] eo;
        int slot;
        int off;

        tests  = 0;
        failed = 0;
        cyc    = 0;
        rst    = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.val0 = 16'h0000;
        bus.val1 = 16'h0000;

        // Reset values and idle scanning
        repeat (3) step();
        check("rst_gnt",    bus.gnt,        2'b00);
        check("rst_ledsel", bus.LEDSEL,     4'hf);
        check("rst_ledout", bus.LEDOUT,     8'hff);
        check("rst_fdone",  bus.frame_done, 1'b0);
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c < 64; c++) begin
            go_to(c);
            check("idle_gnt",    bus.gnt,        2'b00);
            check("idle_ledsel", bus.LEDSEL,     4'hf);
            check("idle_ledout", bus.LEDOUT,     8'hff);
            check("idle_fdone",  bus.frame_done, (c % 32 == 31) ? 1'b1 : 1'b0);
        end

        // Single owner, value 0720
        bus.req0 = 1'b1;
        bus.val0 = 16'h0720;
        do_reset();
        pat[0] = 8'h88;
        pat[1] = 8'ha2;
        pat[2] = 8'had;
        pat[3] = 8'hff;
        for (int c = 0; c < 64; c++) begin
            go_to(c);
            slot = (c / 8) % 4;
            off  = c % 8;
            if (off < 2) begin
                es = 4'hf;
                eo = 8'hff;
            end else begin
                es = ~(4'b0001 << slot);
                eo = pat[slot];
            end
            check("scan_ledsel", bus.LEDSEL, es);
            check("scan_ledout", bus.LEDOUT, eo);
            check("scan_gnt",    bus.gnt,    (c == 0) ? 2'b00 : 2'b01);
        end

        // Tie from reset and hold fairness
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.val0 = 16'h1111;
        bus.val1 = 16'h2222;
        do_reset();
        go_to(1);   check("tie_gnt_1",   bus.gnt,    2'b01);
        go_to(2);   check("tie_out_2",   bus.LEDOUT, 8'hed);
        go_to(31);  check("tie_gnt_31",  bus.gnt,    2'b01);
        go_to(32);  check("tie_gnt_32",  bus.gnt,    2'b01);
        go_to(63);  check("tie_gnt_63",  bus.gnt,    2'b01);
        go_to(64);  check("tie_gnt_64",  bus.gnt,    2'b10);
        go_to(66);  check("tie_out_66",  bus.LEDOUT, 8'ha2);
        go_to(96);  check("tie_gnt_96",  bus.gnt,    2'b10);
        go_to(127); check("tie_gnt_127", bus.gnt,    2'b10);
        go_to(128); check("tie_gnt_128", bus.gnt,    2'b01);

        // Release and handover, then drop both
        bus.req0 = 1'b1;
        bus.req1 = 1'b0;
        bus.val0 = 16'h0001;
        bus.val1 = 16'h0002;
        do_reset();
        go_to(40);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        go_to(41); check("ho_gnt_41",    bus.gnt,    2'b01);
        go_to(42); check("ho_ledsel_42", bus.LEDSEL, 4'hd);
                   check("ho_ledout_42", bus.LEDOUT, 8'hff);
        go_to(63); check("ho_gnt_63",    bus.gnt,    2'b01);
        go_to(64); check("ho_gnt_64",    bus.gnt,    2'b10);
        go_to(66); check("ho_ledsel_66", bus.LEDSEL, 4'he);
                   check("ho_ledout_66", bus.LEDOUT, 8'ha2);
        go_to(80);
        bus.req1 = 1'b0;
        go_to(95); check("ho_gnt_95",    bus.gnt,    2'b10);
        go_to(96); check("ho_gnt_96",    bus.gnt,    2'b00);
        go_to(98); check("ho_ledsel_98", bus.LEDSEL, 4'hf);
                   check("ho_ledout_98", bus.LEDOUT, 8'hff);

        // Value coherence across frames and decode
        bus.req0 = 1'b1;
        bus.req1 = 1'b0;
        bus.val0 = 16'h1234;
        do_reset();
        go_to(40);
        bus.val0 = 16'h5040;
        go_to(42);  check("coh_d1_f2",  bus.LEDOUT, 8'ha4);
        go_to(50);  check("coh_d2_f2",  bus.LEDOUT, 8'ha2);
        go_to(58);  check("coh_d3_f2",  bus.LEDOUT, 8'hed);
                    check("coh_sel_58", bus.LEDSEL, 4'h7);
        go_to(66);  check("coh_d0_f3",  bus.LEDOUT, 8'h88);
        go_to(74);  check("coh_d1_f3",  bus.LEDOUT, 8'hc5);
        go_to(82);  check("coh_d2_f3",  bus.LEDOUT, 8'h88);
        go_to(90);  check("coh_d3_f3",  bus.LEDOUT, 8'h94);
        bus.val0 = 16'h00a0;
        go_to(98);  check("hex_d0",     bus.LEDOUT, 8'h88);
        go_to(106); check("hex_d1",     bus.LEDOUT, 8'hff);
                    check("hex_sel1",   bus.LEDSEL, 4'hd);
        go_to(114); check("hex_d2",     bus.LEDOUT, 8'hff);
        go_to(122); check("hex_d3",     bus.LEDOUT, 8'hff);

        // Reset during DRIVE of digit 2
        bus.val0 = 16'h1234;
        do_reset();
        go_to(19);
        check("mid_sel_19", bus.LEDSEL, 4'hb);
        check("mid_out_19", bus.LEDOUT, 8'ha2);
        rst = 1'b1;
        step();
        check("mid_rst_sel",   bus.LEDSEL,     4'hf);
        check("mid_rst_out",   bus.LEDOUT,     8'hff);
        check("mid_rst_gnt",   bus.gnt,        2'b00);
        check("mid_rst_fdone", bus.frame_done, 1'b0);
        step();
        rst = 1'b0;
        cyc = 0;
        go_to(1);  check("re_gnt_1",   bus.gnt,        2'b01);
                   check("re_sel_1",   bus.LEDSEL,     4'hf);
        go_to(2);  check("re_sel_2",   bus.LEDSEL,     4'he);
                   check("re_out_2",   bus.LEDOUT,     8'hc5);
        go_to(30); check("re_fdone_30", bus.frame_done, 1'b0);
        go_to(31); check("re_fdone_31", bus.frame_done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seg_display_sched.md
# seg_display_sched

Display scheduler for the 4-digit multiplexed seven-segment display on the 50 MHz board clock. It arbitrates display ownership between two requesters (0: synth status, 1: debug/value readout), each presenting a 4-digit BCD value. It scans the digits with an anti-ghosting blank interval and suppresses leading zeros. All arbitration and value capture happen on frame boundaries, so a displayed frame never mixes owners or values.

## Interface
- REFRESH_DIV, 50000: clk50MHz cycles per digit slot (1 kHz digit rate, 250 Hz frame rate); must be > BLANK_CYC.
- BLANK_CYC, 500: cycles at the start of each digit slot with all digits off; must be ≥ 1.
- HOLD_FRAMES, 64: minimum frames an owner keeps the display while the other requester is waiting; must be ≥ 1.

- clk50MHz  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- req0  input  1  requester 0 wants the display (level)
- val0  input  16  requester 0 value, 4 BCD nibbles, [3:0] = rightmost digit
- req1  input  1  requester 1 wants the display (level)
- val1  input  16  requester 1 value, same format
- gnt  output  2  one-hot current owner (bit0 = req0, bit1 = req1); 00 = none
- LEDSEL  output  4  digit enables, active-low; bit n = digit n
- LEDOUT  output  8  segment pattern, active-low
- frame_done  output  1  one-cycle pulse on the last cycle of each frame

## Operation
- Reset values: gnt=00, LEDSEL=4'b1111, LEDOUT=8'hff, frame_done=0, digit index 0, scan state BLANK, slot counter 0, hold counter 0, latched value 0.
- Scan FSM per digit slot: BLANK for BLANK_CYC cycles (LEDSEL=1111, LEDOUT=ff), then DRIVE for REFRESH_DIV−BLANK_CYC cycles (LEDSEL drives digit n low only, LEDOUT = pattern of n). After DRIVE, the index advances 0→1→2→3→0 (2-bit wrap) and the FSM returns to BLANK.
- Frame = 4 slots = 4·REFRESH_DIV cycles. frame_done is high on the last DRIVE cycle of digit 3.
- Frame boundary = the first cycle after rst deasserts, and every frame_done cycle. On the edge ending that cycle, gnt, the hold counter and the latched value update together. The latched value is val0 or val1 of the new owner, sampled that cycle.
- Arbitration at a boundary, with current owner X and other requester Y:
  - Owner none: req0 → grant 0; else req1 → grant 1; else stay none. On any new grant, hold=1.
  - X owns, req_X=1, and (hold<HOLD_FRAMES or req_Y=0): keep X; hold increments, saturating at HOLD_FRAMES.
  - X owns and req_Y=1, with either hold=HOLD_FRAMES or req_X=0: switch to Y, hold=1.
  - X owns, req_X=0, req_Y=0: gnt=00.
- A request dropped mid-frame does not end ownership until the next boundary. Input values are ignored between boundaries.
- With gnt=00, DRIVE slots output LEDSEL=1111, LEDOUT=ff (fully blank).
- Segment decode of each nibble (active-low): 0=88, 1=ed, 2=a2, 3=a4, 4=c5, 5=94, 6=90, 7=ad, 8=80, 9=84. Nibbles a–f decode to ff.
- Leading-zero blanking: digit n (n=3..1) shows ff if its nibble and all higher nibbles are 0. Digit 0 always displays, so a value of 0 shows a single "0".

## Timing
- All outputs are registered. They change on the edge that enters the corresponding state or slot; there is no combinational input-to-output path.
- The first BLANK slot begins on the first cycle after reset release. The value latched at that boundary is displayed from the first DRIVE of digit 0, BLANK_CYC cycles later.
- Request-to-display latency: at most 1 frame + BLANK_CYC cycles if the display is free.
- Reset asserted mid-frame forces all reset values on the next edge and aborts the frame. No frame_done is generated for the aborted frame.
- Simultaneous req0/req1 rise with no owner: req0 wins. req1 is granted after HOLD_FRAMES frames if req0 stays high.

## Test plan
Directed tests run with REFRESH_DIV=8, BLANK_CYC=2, HOLD_FRAMES=2 (frame = 32 cycles).
- Reset/idle: rst high 3 cycles, then low with req0=req1=0 → gnt=00; LEDSEL=1111 and LEDOUT=ff throughout; frame_done pulses every 32 cycles, first on cycle 31 after release.
- Single owner scan: req0=1, val0=16'h0720 → gnt=01 after first boundary. Per frame: digit0=88, digit1=a2, digit2=ad, digit3=ff (blanked). Each digit is driven 6 cycles after 2 blank cycles; LEDSEL sequence is 1110, 1101, 1011, 0111.
- Tie and hold fairness: req0=req1=1 from reset → gnt=01 for frames 1–2, then 10 for frames 3–4, alternating. Changes are seen only the cycle after frame_done.
- Release/handover: owner 0, drop req0 mid-frame with req1=1 → gnt stays 01 to end of frame, then 10. Drop both → gnt=00 and display blank next frame.
- Value coherence and decode: change val0 from 16'h1234 to 16'h5040 mid-frame → the frame in progress shows 1234 entirely, the next shows 5040 (digit3=94, digit2=88, digit1=c5, digit0=88). val0=16'h00a0 → digit1=ff, digit0=88.
- Reset mid-frame: assert rst during DRIVE of digit 2 → next edge LEDSEL=1111, LEDOUT=ff, gnt=00; after release, scan restarts at digit 0 in BLANK.
